cordic_iter: RTL and testbench

Parametrised iterative CORDIC engine, successor to the 16-bit lookup-driven CORDIC core. Runs a full rotation- or vectoring-mode CORDIC sequence from a single start pulse, with an internal iteration counter and arctangent ROM; the caller no longer sequences the ROM address. Fixed-point format is Q2.(WIDTH-2) for x, y and angle (16-bit: 0x4000 = 1.0, 0x54E5 ≈ 1.32645 rad). Sits beside the datapath as a sin/cos and atan/magnitude coprocessor with a start/done handshake.

---
 rtl/cordic_pkg.sv | 36 +++
 rtl/cordic_atan_rom.sv | 28 ++
 rtl/cordic_iter.sv | 202 ++++++++++++++++++++
 tb/tb_cordic_iter.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// cordic_pkg: shared types and constants for the iterative CORDIC engine.
//   cordic_state_e : engine FSM states
//   cordic_mode_e  : rotation / vectoring selector
//   ATAN_Q30       : atan(2^-i), i = 0..31, Q2.30, rounded half-up
//   K_Q30          : CORDIC gain compensation constant 0.607253 in Q2.30
package cordic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_COMP = 2'd2,
    ST_DONE = 2'd3
  } cordic_state_e;

  typedef enum logic {
    MODE_ROT = 1'b0,
    MODE_VEC = 1'b1
  } cordic_mode_e;

  localparam int unsigned ATAN_ENTRIES = 32;
  localparam int unsigned Q30_FRAC     = 30;

  localparam logic [31:0] ATAN_Q30 [ATAN_ENTRIES] = '{
    32'd843314857, 32'd497837829, 32'd263043837, 32'd133525159,
    32'd67021687,  32'd33543516,  32'd16775850,  32'd8388437,
    32'd4194283,   32'd2097149,   32'd1048576,   32'd524288,
    32'd262144,    32'd131072,    32'd65536,     32'd32768,
    32'd16384,     32'd8192,      32'd4096,      32'd2048,
    32'd1024,      32'd512,       32'd256,       32'd128,
    32'd64,        32'd32,        32'd16,        32'd8,
    32'd4,         32'd2,         32'd1,         32'd1
  };

  localparam logic [31:0] K_Q30 = 32'd652032874;

endpackage

// File: rtl/cordic_atan_rom.sv
// cordic_atan_rom: combinational arctangent constant lookup.
// Rescales the Q2.30 table entry to the engine's internal angle format,
// Q2.(WIDTH-2) with GUARD extra fraction bits, in WIDTH+GUARD+1 bits.
//   idx_i     : iteration index 0..31
//   angle_c_o : atan(2^-idx_i) in internal angle format (combinational)
module cordic_atan_rom
  import cordic_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned GUARD = 2
) (
  input  logic [4:0]             idx_i,
  output logic [WIDTH+GUARD:0]   angle_c_o
);

  localparam int unsigned IW   = WIDTH + GUARD + 1;
  localparam int unsigned FRAC = WIDTH - 2 + GUARD;
  localparam int unsigned SHR  = (FRAC < Q30_FRAC) ? (Q30_FRAC - FRAC) : 0;
  localparam int unsigned SHL  = (FRAC > Q30_FRAC) ? (FRAC - Q30_FRAC) : 0;
  // Half-LSB of the target format so narrowing rounds instead of truncating
  localparam logic [63:0] RND  = (SHR == 0) ? 64'd0 : (64'd1 << (SHR - 1));

  // Entries are positive and below 1.0, so the narrowed value always fits
  always_comb begin
    angle_c_o = IW'(((64'(ATAN_Q30[idx_i]) + RND) >> SHR) << SHL);
  end

endmodule

// File: rtl/cordic_iter.sv
// cordic_iter: iterative CORDIC engine, rotation and vectoring modes.
// One start pulse runs ITERS micro-rotations using an internal counter and
// arctangent ROM; results are rounded, saturated and held until next start.
// Optional feature macro: CORDIC_GAIN_COMP_EN adds a COMP state that scales
// x/y by K so outputs are true-scale (one extra cycle of latency).
//   clk_i, rst_i      : clock, asynchronous active-high reset
//   start_i, mode_i   : run request (sampled in IDLE), 0=rotation 1=vectoring
//   x_i, y_i, z_i     : signed Q2.(WIDTH-2) operands
//   busy_o, done_o    : run in progress, one-cycle result-valid pulse
//   x_o, y_o, z_o     : signed Q2.(WIDTH-2) results
//   iter_o            : current iteration index (debug)
module cordic_iter
  import cordic_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned ITERS = 16,
  parameter int unsigned GUARD = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       start_i,
  input  logic                       mode_i,
  input  logic [WIDTH-1:0]           x_i,
  input  logic [WIDTH-1:0]           y_i,
  input  logic [WIDTH-1:0]           z_i,
  output logic                       busy_o,
  output logic                       done_o,
  output logic [WIDTH-1:0]           x_o,
  output logic [WIDTH-1:0]           y_o,
  output logic [WIDTH-1:0]           z_o,
  output logic [$clog2(ITERS+1)-1:0] iter_o
);

  localparam int unsigned IW  = WIDTH + GUARD + 1;
  localparam int unsigned ITW = $clog2(ITERS + 1);
  localparam logic [ITW-1:0] LAST_ITER = ITW'(ITERS - 1);

  // Output narrowing constants: round-half-up offset and signed WIDTH limits
  localparam logic signed [IW:0] RND_OUT = ((IW+1)'(1) << GUARD) >> 1;
  localparam logic signed [IW:0] SAT_MAX = {{(GUARD+3){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [IW:0] SAT_MIN = ~SAT_MAX;

  cordic_state_e           state_q, state_d;
  cordic_mode_e            mode_q,  mode_d;
  logic signed [IW-1:0]    x_q, x_d, y_q, y_d, z_q, z_d;
  logic [ITW-1:0]          iter_q,  iter_d;
  logic                    busy_q,  busy_d;
  logic                    done_q,  done_d;
  logic [WIDTH-1:0]        xo_q, xo_d, yo_q, yo_d, zo_q, zo_d;

  logic [IW-1:0]           atan_c;
  logic signed [IW-1:0]    atan_s;
  logic signed [IW-1:0]    x_sh, y_sh;
  logic signed [IW-1:0]    x_rot, y_rot, z_rot;
  logic                    dir_pos;

  // Drop GUARD LSBs (round half up) and clamp to the signed WIDTH range
  function automatic logic [WIDTH-1:0] round_sat(input logic signed [IW-1:0] v);
    logic signed [IW:0] r;
    r = ((IW+1)'(v) + RND_OUT) >>> GUARD;
    if (r > SAT_MAX)      round_sat = SAT_MAX[WIDTH-1:0];
    else if (r < SAT_MIN) round_sat = SAT_MIN[WIDTH-1:0];
    else                  round_sat = r[WIDTH-1:0];
  endfunction

  cordic_atan_rom #(
    .WIDTH (WIDTH),
    .GUARD (GUARD)
  ) u_atan_rom (
    .idx_i     (5'(iter_q)),
    .angle_c_o (atan_c)
  );

  assign atan_s = $signed(atan_c);

  // One micro-rotation; direction from z sign (rotation) or y sign (vectoring)
  assign x_sh    = x_q >>> iter_q;
  assign y_sh    = y_q >>> iter_q;
  assign dir_pos = (mode_q == MODE_ROT) ? ~z_q[IW-1] : y_q[IW-1];
  assign x_rot   = dir_pos ? (x_q - y_sh)   : (x_q + y_sh);
  assign y_rot   = dir_pos ? (y_q + x_sh)   : (y_q - x_sh);
  assign z_rot   = dir_pos ? (z_q - atan_s) : (z_q + atan_s);

`ifdef CORDIC_GAIN_COMP_EN
  localparam int unsigned PW = IW + 33;
  localparam logic signed [PW-1:0] K_EXT  = PW'(K_Q30);
  localparam logic signed [PW-1:0] K_HALF = PW'(32'h2000_0000);

  logic signed [IW-1:0] x_cmp, y_cmp;

  // Constant gain multiply in Q2.30, rounded back to internal format
  assign x_cmp = IW'((PW'(x_q) * K_EXT + K_HALF) >>> Q30_FRAC);
  assign y_cmp = IW'((PW'(y_q) * K_EXT + K_HALF) >>> Q30_FRAC);
`endif

  // State and datapath registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_ROT;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      iter_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      xo_q    <= '0;
      yo_q    <= '0;
      zo_q    <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      iter_q  <= iter_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      xo_q    <= xo_d;
      yo_q    <= yo_d;
      zo_q    <= zo_d;
    end
  end

  // Next-state and datapath control; done/outputs are set on entry to DONE
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    iter_d  = iter_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    xo_d    = xo_q;
    yo_d    = yo_q;
    zo_d    = zo_q;

    case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        if (start_i) begin
          x_d     = IW'($signed(x_i)) <<< GUARD;
          y_d     = IW'($signed(y_i)) <<< GUARD;
          z_d     = IW'($signed(z_i)) <<< GUARD;
          mode_d  = cordic_mode_e'(mode_i);
          iter_d  = '0;
          busy_d  = 1'b1;
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        x_d    = x_rot;
        y_d    = y_rot;
        z_d    = z_rot;
        iter_d = iter_q + ITW'(1);
        if (iter_q == LAST_ITER) begin
`ifdef CORDIC_GAIN_COMP_EN
          state_d = ST_COMP;
`else
          state_d = ST_DONE;
          done_d  = 1'b1;
          xo_d    = round_sat(x_rot);
          yo_d    = round_sat(y_rot);
          zo_d    = round_sat(z_rot);
`endif
        end
      end

`ifdef CORDIC_GAIN_COMP_EN
      ST_COMP: begin
        x_d     = x_cmp;
        y_d     = y_cmp;
        state_d = ST_DONE;
        done_d  = 1'b1;
        xo_d    = round_sat(x_cmp);
        yo_d    = round_sat(y_cmp);
        zo_d    = round_sat(z_q);
      end
`endif

      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign x_o    = xo_q;
  assign y_o    = yo_q;
  assign z_o    = zo_q;
  assign iter_o = iter_q;

endmodule

// File: tb/tb_cordic_iter.sv
// tb_cordic_iter: self-checking bench for cordic_iter (16-bit and 12-bit
// instances) against a real-arithmetic reference of the CORDIC results.
module tb_cordic_iter;

  localparam int W  = 16;
  localparam int N  = 16;
  localparam int W2 = 12;
  localparam int N2 = 12;
`ifdef CORDIC_GAIN_COMP_EN
  localparam bit COMP = 1'b1;
`else
  localparam bit COMP = 1'b0;
`endif
  localparam int LAT  = COMP ? N + 1  : N;
  localparam int LAT2 = COMP ? N2 + 1 : N2;

  logic        clk;
  logic        rst;
  logic        start, mode;
  logic [15:0] xi, yi, zi, xo, yo, zo;
  logic        busy, done;
  logic [4:0]  iter;

  logic        start2, mode2;
  logic [11:0] xi2, yi2, zi2, xo2, yo2, zo2;
  logic        busy2, done2;
  logic [3:0]  iter2;

  int n_tests = 0;
  int n_fail  = 0;

  cordic_iter #(.WIDTH(W), .ITERS(N), .GUARD(2)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .mode_i(mode),
    .x_i(xi), .y_i(yi), .z_i(zi),
    .busy_o(busy), .done_o(done),
    .x_o(xo), .y_o(yo), .z_o(zo), .iter_o(iter)
  );

  cordic_iter #(.WIDTH(W2), .ITERS(N2), .GUARD(2)) dut12 (
    .clk_i(clk), .rst_i(rst), .start_i(start2), .mode_i(mode2),
    .x_i(xi2), .y_i(yi2), .z_i(zi2),
    .busy_o(busy2), .done_o(done2),
    .x_o(xo2), .y_o(yo2), .z_o(zo2), .iter_o(iter2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input longint got, input longint exp, input longint tol);
    longint diff;
    n_tests++;
    diff = got - exp;
    if (diff < 0) diff = -diff;
    if (diff > tol) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (tol %0d)", tag, got, exp, tol);
    end
  endtask

  // Overall CORDIC gain for the build: An, times K when compensated
  function automatic real gain(input int iters);
    real g;
    g = 1.0;
    for (int i = 0; i < iters; i++) g = g * $sqrt(1.0 + $pow(2.0, -2.0 * i));
    if (COMP) g = g * 0.6072529350088813;
    return g;
  endfunction

  function automatic longint sat(input real v, input int w);
    longint r, lim;
    lim = longint'(1) << (w - 1);
    r = longint'(v);
    if (r > lim - 1) r = lim - 1;
    if (r < -lim) r = -lim;
    return r;
  endfunction

  // Ideal results: rotation rotates (x,y) by z; vectoring gives |(x,y)| and atan2
  task automatic model(input bit m, input int x, input int y, input int z,
                       input int w, input int iters,
                       output longint ex, output longint ey, output longint ez);
    real g, s, zr, xr, yr;
    g  = gain(iters);
    s  = $pow(2.0, w - 2);
    xr = real'(x);
    yr = real'(y);
    zr = real'(z) / s;
    if (!m) begin
      ex = sat(g * (xr * $cos(zr) - yr * $sin(zr)), w);
      ey = sat(g * (yr * $cos(zr) + xr * $sin(zr)), w);
      ez = 0;
    end else begin
      ex = sat(g * $sqrt(xr * xr + yr * yr), w);
      ey = 0;
      ez = sat($atan2(yr, xr) * s, w);
    end
  endtask

  // Start one run on the 16-bit DUT from an IDLE negedge; ends in IDLE
  task automatic run16(input bit m, input int x, input int y, input int z);
    int lat;
    mode  = m;
    xi    = 16'(x);
    yi    = 16'(y);
    zi    = 16'(z);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", longint'(busy), 1, 0);
    lat = 0;
    while (!done && lat < 200) begin
      @(negedge clk);
      lat++;
      if (lat == 3) check("iter_at_edge3", longint'(iter), 3, 0);
    end
    check("latency", lat, LAT, 0);
    @(negedge clk);
    check("done_one_cycle", longint'(done), 0, 0);
  endtask

  task automatic cmp16(input string tag, input bit m, input int x, input int y, input int z);
    longint ex, ey, ez;
    model(m, x, y, z, W, N, ex, ey, ez);
    check({tag, "_x"}, longint'($signed(xo)), ex, 8);
    check({tag, "_y"}, longint'($signed(yo)), ey, 8);
    check({tag, "_z"}, longint'($signed(zo)), ez, 6);
  endtask

  initial begin
    int lat;
    int rx, ry, rz;
    rst = 1'b0; start = 1'b0; mode = 1'b0; xi = '0; yi = '0; zi = '0;
    start2 = 1'b0; mode2 = 1'b0; xi2 = '0; yi2 = '0; zi2 = '0;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy", longint'(busy), 0, 0);
    check("rst_done", longint'(done), 0, 0);
    check("rst_x", longint'(xo), 0, 0);
    check("rst_y", longint'(yo), 0, 0);
    check("rst_z", longint'(zo), 0, 0);
    check("rst_iter", longint'(iter), 0, 0);
    rst = 1'b0;
    @(negedge clk);

    // Directed rotation by ~1.3265 rad of (1.0, 0)
    run16(1'b0, 16'h4000, 0, 16'h54E5);
    check("dir_rot_x", longint'($signed(xo)), COMP ? 16'h0F7B : 16'h197F, COMP ? 4 : 8);
    check("dir_rot_y", longint'($signed(yo)), COMP ? 16'h3E19 : 16'h6644, COMP ? 4 : 8);
    check("dir_rot_z", longint'($signed(zo)), 0, 4);
    cmp16("dir_rot", 1'b0, 16'h4000, 0, 16'h54E5);

    // Directed vectoring of (0.5, 0.5): angle pi/4
    run16(1'b1, 16'h2000, 16'h2000, 0);
    check("dir_vec_z", longint'($signed(zo)), 16'h3244, 4);
    if (COMP) check("dir_vec_x", longint'($signed(xo)), 16'h2D41, 4);
    cmp16("dir_vec", 1'b1, 16'h2000, 16'h2000, 0);

    // Random operands inside the convergence domain
    for (int k = 0; k < 12; k++) begin
      rx = int'($urandom_range(24576, 0)) - 12288;
      ry = int'($urandom_range(24576, 0)) - 12288;
      rz = int'($urandom_range(55706, 0)) - 27853;
      run16(1'b0, rx, ry, rz);
      cmp16($sformatf("rnd_rot%0d", k), 1'b0, rx, ry, rz);
    end
    for (int k = 0; k < 12; k++) begin
      rx = int'($urandom_range(12288, 4096));
      ry = int'($urandom_range(24576, 0)) - 12288;
      run16(1'b1, rx, ry, 0);
      cmp16($sformatf("rnd_vec%0d", k), 1'b1, rx, ry, 0);
    end

    // start pulsed mid-run then held: first run unaffected, second accepted after IDLE
    mode = 1'b0; xi = 16'h2000; yi = 16'h1000; zi = 16'h1800;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (lat < 5) begin
      @(negedge clk);
      lat++;
    end
    start = 1'b1; mode = 1'b0; xi = 16'h3000; yi = 16'h1000; zi = 16'h2000;
    while (!done && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check("held_latency1", lat, LAT, 0);
    check("held_busy_at_done", longint'(busy), 1, 0);
    cmp16("held_first", 1'b0, 16'h2000, 16'h1000, 16'h1800);
    @(negedge clk);
    check("held_idle_done", longint'(done), 0, 0);
    check("held_idle_busy", longint'(busy), 0, 0);
    @(negedge clk);
    check("held_accept_busy", longint'(busy), 1, 0);
    check("held_accept_iter", longint'(iter), 0, 0);
    start = 1'b0;
    lat = 0;
    while (!done && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check("held_latency2", lat, LAT, 0);
    cmp16("held_second", 1'b0, 16'h3000, 16'h1000, 16'h2000);
    @(negedge clk);

    // Asynchronous reset at iteration 7 clears everything immediately
    mode = 1'b1; xi = 16'h1800; yi = 16'hF000; zi = 16'h0000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (lat < 7) begin
      @(negedge clk);
      lat++;
    end
    check("midrun_iter", longint'(iter), 7, 0);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", longint'(busy), 0, 0);
    check("arst_done", longint'(done), 0, 0);
    check("arst_x", longint'(xo), 0, 0);
    check("arst_y", longint'(yo), 0, 0);
    check("arst_z", longint'(zo), 0, 0);
    check("arst_iter", longint'(iter), 0, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run16(1'b1, 16'h1800, 16'hF000, 0);
    cmp16("after_rst", 1'b1, 16'h1800, -16'sh1000, 0);

    // 12-bit boundary: max positive x with z=0 must saturate, never wrap
    mode2 = 1'b0; xi2 = 12'h7FF; yi2 = '0; zi2 = '0;
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    lat = 0;
    while (!done2 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check("w12_latency", lat, LAT2, 0);
    check("w12_x_sat", longint'($signed(xo2)), 2047, COMP ? 4 : 0);
    check("w12_x_sign", longint'(xo2[11]), 0, 0);
    check("w12_y", longint'($signed(yo2)), 0, 4);
    check("w12_z", longint'($signed(zo2)), 0, 4);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
